odd_parity_frame_ctrl: RTL and testbench

Serial front-end controller for the 9-bit odd-parity check path. It sequences reception of one frame (DATA_W data bits plus 1 odd-parity bit, MSB first) from a bit-strobe interface and runs the odd-parity check on the assembled word. It presents the data byte and error flag on a valid/ready output handshake. It also keeps saturating frame and error statistics for the status block.

---
 rtl/odd_parity_frame_ctrl.sv | 116 +++++++++++
 tb/tb_odd_parity_frame_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/odd_parity_frame_ctrl.sv
// Serial receiver for DATA_W data bits plus one odd-parity bit (MSB first),
// with a valid/ready result port and saturating frame/error statistics.
module odd_parity_frame_ctrl #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              bit_valid,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_abort,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int BC_W = $clog2(DATA_W + 2);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    // bit_cnt holds the number of bits already captured, so the final
    // (parity) bit arrives while bit_cnt == DATA_W.
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_W);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, OUT} state_t;

    state_t            state;
    logic [DATA_W:0]   shift_reg;
    logic [BC_W-1:0]   bit_cnt;
    logic [TO_W-1:0]   to_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            data_out    <= '0;
            parity_err  <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_abort <= 1'b0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    // A restart wins over a coincident strobe; that bit is dropped.
                    if (frame_start) begin
                        bit_cnt     <= '0;
                        to_cnt      <= '0;
                        frame_abort <= 1'b1;
                    end else if (bit_valid) begin
                        shift_reg <= {shift_reg[DATA_W-1:0], rx_bit};
                        to_cnt    <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            state   <= CHECK;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        frame_abort <= 1'b1;
                        bit_cnt     <= '0;
                        to_cnt      <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                CHECK: begin
                    parity_err <= ~^shift_reg;
                    data_out   <= shift_reg[DATA_W:1];
                    out_valid  <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        frame_cnt <= sat_inc(frame_cnt);
                        if (parity_err) begin
                            err_cnt <= sat_inc(err_cnt);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_odd_parity_frame_ctrl.sv
// Randomized self-checking bench for odd_parity_frame_ctrl with a frame-level
// reference model (parity from a ones count, saturating statistics).
module tb_odd_parity_frame_ctrl;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              frame_start = 1'b0;
    logic              bit_valid = 1'b0;
    logic              rx_bit = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              parity_err;
    logic              out_valid;
    logic              busy;
    logic              frame_abort;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  err_cnt;

    int n_vec  = 0;
    int n_fail = 0;
    int exp_frames = 0;
    int exp_errs   = 0;

    odd_parity_frame_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .bit_valid(bit_valid),
        .rx_bit(rx_bit), .data_out(data_out), .parity_err(parity_err),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .frame_abort(frame_abort), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // Reference model: odd parity means the whole frame holds an odd ones count.
    function automatic logic ref_err(input logic [DATA_W:0] f);
        return ($countones(f) % 2) == 0;
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1; frame_start = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;
        exp_frames = 0;
        exp_errs   = 0;
    endtask

    task automatic shift_bits(input logic [DATA_W:0] f, input int max_gap);
        for (int i = DATA_W; i >= 0; i--) begin
            int gap;
            gap = 0;
            if (max_gap > 0)
                gap = ($urandom_range(7, 0) == 0) ? TIMEOUT - 1 : $urandom_range(max_gap, 0);
            bit_valid = 1'b0;
            repeat (gap) begin
                rx_bit = 1'($urandom);
                cyc();
                n_vec++;
                if (frame_abort !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gap_idle: got abort=%b busy=%b, want abort=0 busy=1", frame_abort, busy);
                end
            end
            bit_valid = 1'b1;
            rx_bit    = f[i];
            cyc();
        end
        bit_valid = 1'b0;
    endtask

    task automatic finish_frame(input logic [DATA_W:0] f, input int hold, input bit noise);
        logic [DATA_W-1:0] ed;
        logic              ee;
        ed = f[DATA_W:1];
        ee = ref_err(f);
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL check_cycle: got valid=%b busy=%b, want valid=0 busy=1", out_valid, busy);
        end
        cyc();
        n_vec++;
        if (out_valid !== 1'b1 || data_out !== ed || parity_err !== ee) begin
            n_fail++;
            $display("FAIL result: got valid=%b data=%h err=%b, want valid=1 data=%h err=%b",
                     out_valid, data_out, parity_err, ed, ee);
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            if (noise) begin
                frame_start = 1'($urandom);
                bit_valid   = 1'($urandom);
                rx_bit      = 1'($urandom);
            end
            cyc();
            n_vec++;
            if (out_valid !== 1'b1 || data_out !== ed || parity_err !== ee ||
                frame_cnt !== CNT_W'(exp_frames) || err_cnt !== CNT_W'(exp_errs)) begin
                n_fail++;
                $display("FAIL hold: got valid=%b data=%h err=%b fc=%0d ec=%0d, want 1 %h %b %0d %0d",
                         out_valid, data_out, parity_err, frame_cnt, err_cnt, ed, ee, exp_frames, exp_errs);
            end
        end
        frame_start = 1'b0;
        bit_valid   = 1'b0;
        out_ready   = 1'b1;
        cyc();
        out_ready = 1'b0;
        exp_frames = sat(exp_frames + 1);
        if (ee) exp_errs = sat(exp_errs + 1);
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || data_out !== ed || parity_err !== ee ||
            frame_cnt !== CNT_W'(exp_frames) || err_cnt !== CNT_W'(exp_errs)) begin
            n_fail++;
            $display("FAIL handshake: got valid=%b busy=%b data=%h err=%b fc=%0d ec=%0d, want 0 0 %h %b %0d %0d",
                     out_valid, busy, data_out, parity_err, frame_cnt, err_cnt, ed, ee, exp_frames, exp_errs);
        end
    endtask

    task automatic deliver(input logic [DATA_W:0] f, input int max_gap, input int hold, input bit noise);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busy: got busy=%b, want 1", busy);
        end
        shift_bits(f, max_gap);
        finish_frame(f, hold, noise);
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if (data_out !== '0 || parity_err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            frame_abort !== 1'b0 || frame_cnt !== '0 || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got data=%h err=%b valid=%b busy=%b abort=%b fc=%0d ec=%0d, want all 0",
                     data_out, parity_err, out_valid, busy, frame_abort, frame_cnt, err_cnt);
        end
    endtask

    task automatic test_zero_frame();
        deliver('0, 0, 0, 1'b0);
    endtask

    task automatic test_known_frames();
        apply_reset();
        deliver(9'b101000011, 0, 0, 1'b0);
        deliver(9'b110100010, 0, 0, 1'b0);
        deliver(9'b111111111, 0, 0, 1'b0);
        n_vec++;
        if (frame_cnt !== 8'd3 || err_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL known_counts: got fc=%0d ec=%0d, want 3 2", frame_cnt, err_cnt);
        end
    endtask

    task automatic test_backpressure();
        deliver(9'b100000000, 0, 5, 1'b1);
    endtask

    task automatic test_timeout();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        bit_valid = 1'b1;
        repeat (4) begin
            rx_bit = 1'($urandom);
            cyc();
        end
        bit_valid = 1'b0;
        repeat (TIMEOUT - 1) cyc();
        n_vec++;
        if (frame_abort !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: got abort=%b busy=%b, want 0 1", frame_abort, busy);
        end
        cyc();
        n_vec++;
        if (frame_abort !== 1'b1 || busy !== 1'b0 || frame_cnt !== CNT_W'(exp_frames) ||
            err_cnt !== CNT_W'(exp_errs)) begin
            n_fail++;
            $display("FAIL timeout_abort: got abort=%b busy=%b fc=%0d ec=%0d, want 1 0 %0d %0d",
                     frame_abort, busy, frame_cnt, err_cnt, exp_frames, exp_errs);
        end
        cyc();
        n_vec++;
        if (frame_abort !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got abort=%b, want 0", frame_abort);
        end
        deliver(9'b111111111, 0, 0, 1'b0);
    endtask

    task automatic test_restart();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        bit_valid = 1'b1;
        repeat (5) begin
            rx_bit = 1'($urandom);
            cyc();
        end
        frame_start = 1'b1;
        bit_valid   = 1'b1;
        rx_bit      = 1'b1;
        cyc();
        frame_start = 1'b0;
        bit_valid   = 1'b0;
        n_vec++;
        if (frame_abort !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_abort: got abort=%b busy=%b, want 1 1", frame_abort, busy);
        end
        shift_bits(9'b101000011, 2);
        finish_frame(9'b101000011, 0, 1'b0);
    endtask

    task automatic test_reset_midframe();
        deliver(9'b111111111, 0, 0, 1'b0);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        bit_valid = 1'b1;
        repeat (4) begin
            rx_bit = 1'($urandom);
            cyc();
        end
        bit_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_frames = 0;
        exp_errs   = 0;
        n_vec++;
        if (data_out !== '0 || parity_err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            frame_abort !== 1'b0 || frame_cnt !== '0 || err_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got data=%h err=%b valid=%b busy=%b abort=%b fc=%0d ec=%0d, want all 0",
                     data_out, parity_err, out_valid, busy, frame_abort, frame_cnt, err_cnt);
        end
        cyc();
        n_vec++;
        if (frame_abort !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_noabort: got abort=%b busy=%b, want 0 0", frame_abort, busy);
        end
    endtask

    task automatic test_random();
        repeat (30) begin
            logic [DATA_W:0] f;
            f = (DATA_W+1)'($urandom);
            deliver(f, 3, $urandom_range(3, 0), 1'b1);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        repeat (CNT_MAX + 4) begin
            logic [DATA_W:0] f;
            f = (DATA_W+1)'($urandom);
            if (!ref_err(f)) f[0] = ~f[0];
            deliver(f, 0, 0, 1'b0);
        end
        n_vec++;
        if (frame_cnt !== 8'hFF || err_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL saturation: got fc=%h ec=%h, want ff ff", frame_cnt, err_cnt);
        end
    endtask

    initial begin
        cyc();
        test_reset();
        test_zero_frame();
        test_known_frames();
        test_backpressure();
        test_timeout();
        test_restart();
        test_reset_midframe();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
